ram16sdp_arbiter: RTL and testbench
===================================

RAM16SDP_ARBITER -- requirements
Module: ram16sdp_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, RAM word address width; DATA_W, default 32, RAM data width; DEPTH, default 1024, number of RAM words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic, which also drives RAM clka and clkb.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports req_valid[1:0], input, 2 bits, and req_ready[1:0], output, 2 bits: per-requester request handshake.
REQ-005 SHALL have port req_we[1:0], input, 2 bits: 1 = write, 0 = read, per requester.
REQ-006 SHALL have ports req_addr[2*ADDR_W-1:0] and req_wdata[2*DATA_W-1:0], inputs: per-requester address and write data, with requester i in slice i.
REQ-007 SHALL have ports rsp_valid[1:0], output, 2 bits, and rsp_rdata[DATA_W-1:0], output: read response (shared data bus, qualified per requester).
REQ-008 SHALL have ports clear_start, input, 1 bit, and clear_done, output, 1 bit: zero-fill control and status.
REQ-009 SHALL have RAM-side ports ram_cea (output, 1), ram_ada (output, ADDR_W), ram_din (output, DATA_W), ram_ceb (output, 1), ram_adb (output, ADDR_W) and ram_dout (input, DATA_W).

Function
REQ-010 SHALL treat a transfer for requester i as occurring on any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-011 SHALL drive req_ready combinationally; req_ready[i] SHALL be 1 only in state RUN and only when requester i wins arbitration for its request type.
REQ-012 SHALL arbitrate write and read requests independently, so that one write and one read from different requesters are both granted in the same cycle.
REQ-013 SHALL resolve contention (both requesters valid with the same req_we) using a per-type round-robin pointer (rr_wr, rr_rd): the pointed-to requester wins, and the pointer then moves to the loser.
REQ-014 SHALL leave the round-robin pointers unchanged on any cycle without contention.
REQ-015 SHALL, on a granted write, set ram_cea=1, ram_ada=winner address and ram_din=winner data in the same cycle; otherwise ram_cea=0.
REQ-016 SHALL, on a granted read, set ram_ceb=1 and ram_adb=winner address in the same cycle; otherwise ram_ceb=0.
REQ-017 SHALL register the read winner, so that rsp_valid[i] pulses exactly one cycle after the grant, with rsp_rdata=ram_dout (1-cycle RAM latency); responses SHALL have no backpressure.
REQ-018 SHALL NOT bypass a same-cycle write and read to the same address: the read returns the pre-write data.
REQ-019 SHALL NOT let a requester change req_addr, req_wdata or req_we while its req_valid=1 and its req_ready=0; behaviour when this rule is violated is undefined.
REQ-020 SHALL implement an FSM with states CLEAR and RUN.
REQ-021 SHALL, in state CLEAR, hold req_ready=0, write zero to address clr_cnt on every cycle (ram_cea=1) and increment clr_cnt.
REQ-022 SHALL move from CLEAR to RUN in the cycle after address DEPTH-1 is written, setting clear_done=1.
REQ-023 SHALL, in state RUN, take clear_start=1 to mean: go to CLEAR, set clr_cnt=0 and set clear_done=0; outstanding read responses SHALL still be delivered.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force: rsp_valid=0, rr_wr=0, rr_rd=0 and clr_cnt=0; ram_cea=0, ram_ceb=0 and req_ready=0.
REQ-025 SHALL, after rst_n deasserts, enter CLEAR with clear_done=0 if RAM_ARB_CLEAR_EN is defined, and RUN otherwise.
REQ-026 SHALL, if rst_n asserts in the middle of a clear, restart the clear from address 0 on release; a pending rsp_valid SHALL be dropped.

Configuration
REQ-027 SHALL, when macro RAM_ARB_CLEAR_EN is defined, compile in the CLEAR state, the clr_cnt counter and clear_start handling.
REQ-028 SHALL, when RAM_ARB_CLEAR_EN is undefined, remain permanently in RUN, tie clear_done to 1 and ignore clear_start.

Verification
REQ-029 SHALL cover: clear enabled, reset released -> 1024 consecutive ram_cea writes of 0 to addresses 0..1023, then clear_done=1 and req_ready active.
REQ-030 SHALL cover: req0 write addr 5 data 0xDEADBEEF, then req0 read addr 5 -> rsp_valid[0] one cycle after the grant with rsp_rdata=0xDEADBEEF.
REQ-031 SHALL cover: both requesters reading continuously -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-032 SHALL cover: req0 write addr 7 and req1 read addr 7 in the same cycle -> both granted, and req1 receives the old value (0 after clear).
REQ-033 SHALL cover: reset pulsed at clr_cnt=300 -> clear restarts at address 0 and clear_done rises only after all 1024 addresses are written.
REQ-034 SHALL cover: clear_start pulsed in RUN with a read granted the same cycle -> rsp_valid is still delivered, then the clear sequence begins.

Source files
------------

// File: rtl/ram16sdp_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM with optional zero-fill.
// Define RAM_ARB_CLEAR_EN to compile in the CLEAR state and clear_start handling.
module ram16sdp_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    input  logic                  clear_start,
    output logic                  clear_done,
    output logic                  ram_cea,
    output logic [ADDR_W-1:0]     ram_ada,
    output logic [DATA_W-1:0]     ram_din,
    output logic                  ram_ceb,
    output logic [ADDR_W-1:0]     ram_adb,
    input  logic [DATA_W-1:0]     ram_dout
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        state;
    logic              rr_wr;
    logic              rr_rd;
    logic [1:0]        wr_req;
    logic [1:0]        rd_req;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_gnt;
    logic              wr_win;
    logic              rd_win;
    logic              run;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rsp_q;

    assign wr_req   = req_valid & req_we;
    assign rd_req   = req_valid & ~req_we;
    assign run      = rst_n && (state == S_RUN);
    assign clearing = rst_n && (state == S_CLEAR);

    // On contention the pointer picks; otherwise the lone requester wins.
    assign wr_win = (wr_req == 2'b11) ? rr_wr : wr_req[1];
    assign rd_win = (rd_req == 2'b11) ? rr_rd : rd_req[1];

    assign wr_gnt = (run && wr_req != 2'b00) ? (2'b01 << wr_win) : 2'b00;
    assign rd_gnt = (run && rd_req != 2'b00) ? (2'b01 << rd_win) : 2'b00;

    assign req_ready = wr_gnt | rd_gnt;

    assign wr_addr = wr_win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign wr_data = wr_win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign rd_addr = rd_win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];

    assign ram_cea = clearing || (wr_gnt != 2'b00);
    assign ram_ada = clearing ? clr_addr : wr_addr;
    assign ram_din = clearing ? '0 : wr_data;
    assign ram_ceb = rd_gnt != 2'b00;
    assign ram_adb = rd_addr;

    assign rsp_valid = rsp_q;
    assign rsp_rdata = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_wr <= 1'b0;
            rr_rd <= 1'b0;
            rsp_q <= 2'b00;
        end else begin
            if (run && wr_req == 2'b11)
                rr_wr <= ~wr_win;
            if (run && rd_req == 2'b11)
                rr_rd <= ~rd_win;
            rsp_q <= rd_gnt;
        end
    end

`ifdef RAM_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] clr_cnt;
    logic              done_q;

    assign clr_addr   = clr_cnt;
    assign clear_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            done_q  <= 1'b0;
        end else if (state == S_CLEAR) begin
            if (clr_cnt == LAST) begin
                state   <= S_RUN;
                clr_cnt <= '0;
                done_q  <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end else if (clear_start) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            done_q  <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign state      = S_RUN;
    assign clr_addr   = '0;
    assign clear_done = 1'b1;
    assign unused_cfg = clear_start ^ (DEPTH == 0);
`endif

endmodule

// File: tb/tb_ram16sdp_arbiter.sv
// Randomized and directed bench for ram16sdp_arbiter with a behavioural RAM.
// Clear-sequence scenarios run only when RAM_ARB_CLEAR_EN is defined.
module tb_ram16sdp_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0]      req_we = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            clear_start = 1'b0;
    logic            clear_done;
    logic            ram_cea;
    logic [AW-1:0]   ram_ada;
    logic [DW-1:0]   ram_din;
    logic            ram_ceb;
    logic [AW-1:0]   ram_adb;
    logic [DW-1:0]   ram_dout = '0;

    int checks = 0;
    int errors = 0;

    // Environment RAM: read-before-write, one-cycle latency.
    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    // Reference contents as the requesters should see them.
    logic [DW-1:0] model [DEPTH] = '{default: '0};

    int            ptr_wr = 0;
    int            ptr_rd = 0;
    logic [1:0]    exp_rsp = 2'b00;
    logic [DW-1:0] exp_rdata = '0;
    logic [1:0]    last_gnt = 2'b00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ceb) ram_dout <= ram[ram_adb];
        if (ram_cea) ram[ram_ada] <= ram_din;
    end

    ram16sdp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clear_start(clear_start), .clear_done(clear_done),
        .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
        .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_dout(ram_dout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One RUN cycle: drive, predict from the arbitration rules, check, advance model.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic cs);
        logic [1:0]    wc;
        logic [1:0]    rc;
        logic [1:0]    eg;
        int            ww;
        int            rw;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        a[0] = a0; a[1] = a1;
        d[0] = d0; d[1] = d1;
        req_valid   = v;
        req_we      = we;
        req_addr    = {a1, a0};
        req_wdata   = {d1, d0};
        clear_start = cs;
        @(negedge clk);
        wc = v & we;
        rc = v & ~we;
        ww = (wc == 2'b11) ? ptr_wr : (wc[1] ? 1 : 0);
        rw = (rc == 2'b11) ? ptr_rd : (rc[1] ? 1 : 0);
        eg = 2'b00;
        if (wc != 2'b00) eg[ww] = 1'b1;
        if (rc != 2'b00) eg[rw] = 1'b1;
        check("req_ready", req_ready, eg);
        check("ram_cea", ram_cea, wc != 2'b00);
        if (wc != 2'b00) begin
            check("ram_ada", ram_ada, a[ww]);
            check("ram_din", ram_din, d[ww]);
        end
        check("ram_ceb", ram_ceb, rc != 2'b00);
        if (rc != 2'b00) check("ram_adb", ram_adb, a[rw]);
        check("rsp_valid", rsp_valid, exp_rsp);
        if (exp_rsp != 2'b00) check("rsp_rdata", rsp_rdata, exp_rdata);
        exp_rsp = 2'b00;
        if (rc != 2'b00) begin
            exp_rsp[rw] = 1'b1;
            exp_rdata   = model[a[rw]];
        end
        if (wc != 2'b00) model[a[ww]] = d[ww];
        if (wc == 2'b11) ptr_wr = 1 - ww;
        if (rc == 2'b11) ptr_rd = 1 - rw;
        last_gnt = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    endtask

`ifdef RAM_ARB_CLEAR_EN
    task automatic clear_run(input int first, input int last_i);
        req_valid   = 2'b11;
        req_we      = 2'b00;
        clear_start = 1'b0;
        for (int i = first; i <= last_i; i++) begin
            @(negedge clk);
            check($sformatf("clear_%0d", i),
                  {ram_cea, ram_ada, ram_din, req_ready, clear_done},
                  {1'b1, AW'(i), {DW{1'b0}}, 2'b00, 1'b0});
        end
    endtask

    task automatic clear_finish();
        @(negedge clk);
        check("clear_done", clear_done, 1'b1);
        check("ready_after_clear", req_ready, 2'b01 << ptr_rd);
        req_valid = 2'b00;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_rsp = 2'b00;
        @(posedge clk);
        #1;
    endtask
`endif

    logic [1:0]    hv;
    logic [1:0]    hwe;
    logic [AW-1:0] ha [2];
    logic [DW-1:0] hd [2];

    initial begin
        hv = 2'b00;
        hwe = 2'b00;
        ha[0] = '0; ha[1] = '0;
        hd[0] = '0; hd[1] = '0;

        // Reset state with live requests applied.
        req_valid = 2'b11;
        req_we    = 2'b01;
        #12;
        check("rst_ready", req_ready, 2'b00);
        check("rst_cea", ram_cea, 1'b0);
        check("rst_ceb", ram_ceb, 1'b0);
        check("rst_rsp", rsp_valid, 2'b00);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef RAM_ARB_CLEAR_EN
        clear_run(0, DEPTH - 1);
        clear_finish();
`else
        @(negedge clk);
        check("clear_done_tied", clear_done, 1'b1);
        @(posedge clk);
        #1;
`endif

        // Write then read back address 5.
        step(2'b01, 2'b01, 10'd5, 10'd0, 32'hDEADBEEF, 32'h0, 1'b0);
        step(2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0, 1'b0);
        check("rd5_gnt", last_gnt, 2'b01);
        idle();

        // Continuous contending reads alternate starting with requester 0.
        step(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, 1'b0);
        check("rr_rd_0", last_gnt, 2'b01);
        step(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, 1'b0);
        check("rr_rd_1", last_gnt, 2'b10);
        step(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, 1'b0);
        check("rr_rd_2", last_gnt, 2'b01);
        step(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, 1'b0);
        check("rr_rd_3", last_gnt, 2'b10);
        idle();

        // Same-cycle write and read of address 7 from different requesters.
        step(2'b11, 2'b01, 10'd7, 10'd7, 32'h1234_5678, 32'h0, 1'b0);
        check("wr_rd_both", last_gnt, 2'b11);
        idle();
        step(2'b10, 2'b00, 10'd0, 10'd7, '0, '0, 1'b0);
        idle();

        // Random traffic, holding stalled requests stable.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(hv[i] && !last_gnt[i])) begin
                    hv[i]  = $urandom_range(0, 3) != 0;
                    hwe[i] = $urandom_range(0, 1) == 1;
                    ha[i]  = AW'($urandom_range(0, 15));
                    hd[i]  = $urandom;
                end
            end
            step(hv, hwe, ha[0], ha[1], hd[0], hd[1], 1'b0);
        end
        idle();

`ifdef RAM_ARB_CLEAR_EN
        // clear_start with a read granted in the same cycle.
        step(2'b10, 2'b00, 10'd0, 10'd5, '0, '0, 1'b1);
        check("cs_rd_gnt", last_gnt, 2'b10);
        clear_start = 1'b0;
        req_valid   = 2'b00;
        @(negedge clk);
        check("cs_rsp_valid", rsp_valid, exp_rsp);
        check("cs_rsp_rdata", rsp_rdata, exp_rdata);
        check("cs_clear_0", {ram_cea, ram_ada, ram_din, clear_done},
              {1'b1, AW'(0), {DW{1'b0}}, 1'b0});
        clear_run(1, 300);
        // Reset in the middle of the clear; it must restart from 0.
        #2;
        rst_n = 1'b0;
        #1;
        check("midclr_rst_cea", ram_cea, 1'b0);
        check("midclr_rst_ready", req_ready, 2'b00);
        ptr_wr = 0;
        ptr_rd = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_run(0, DEPTH - 1);
        clear_finish();
        step(2'b01, 2'b00, 10'd5, 10'd0, '0, '0, 1'b0);
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
